ad_capture_ctrl: RTL



---
 rtl/ad_pkg.sv | 21 ++
 rtl/ad_cap_xfer.sv | 59 +++++
 rtl/ad_capture_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/ad_pkg.sv
// ad_pkg: state encoding and default sizes shared by the ADC capture sequencer
// and its transfer datapath.
package ad_pkg;

   localparam int AD_DATA_WIDTH   = 8;
   localparam int DATA_W_DEF      = 2 * AD_DATA_WIDTH;
   localparam int CNT_W_DEF       = 16;
   localparam int SETTLE_CYC_DEF  = 100;
   localparam int TIMEOUT_CYC_DEF = 1000000;
   localparam int TO_W_DEF        = 20;

   typedef enum logic [2:0] {
      IDLE,
      PWRUP,
      ARM,
      CAPTURE,
      DONE,
      ERR
   } state_e;

endpackage

// File: rtl/ad_cap_xfer.sv
// ad_cap_xfer: read-issue / write-follow pipeline between the wrapper FIFO and
// the downstream buffer, with issued/written word counters and the stall timeout.
module ad_cap_xfer
   import ad_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int TO_W        = TO_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_clr,
   input  logic              i_run,
   input  logic [CNT_W-1:0]  i_tgt,
   input  logic              i_rd_empty,
   input  logic              i_wr_full,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic              o_rd_en,
   output logic              o_wreq,
   output logic [DATA_W-1:0] o_wdata,
   output logic [CNT_W-1:0]  o_words,
   output logic              o_last,
   output logic              o_timeout
);

   logic [CNT_W-1:0] issued_q, issued_d;
   logic [CNT_W-1:0] words_q, words_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic             wr_q;

   always_comb begin
      o_rd_en   = i_run && !i_rd_empty && !i_wr_full && (issued_q < i_tgt);
      issued_d  = i_clr ? '0 : issued_q + CNT_W'(o_rd_en);
      words_d   = i_clr ? '0 : words_q + CNT_W'(wr_q && (words_q < i_tgt));
      // Counter holds cycles since the last read; cleared whenever not capturing.
      to_d      = !i_run ? '0 : o_rd_en ? TO_W'(1) : to_q + TO_W'(1);
      o_timeout = i_run && !o_rd_en && (to_q == TO_W'(TIMEOUT_CYC - 1));
      o_last    = wr_q && (words_q == i_tgt - CNT_W'(1));
      o_wreq    = wr_q;
      o_wdata   = wr_q ? i_rd_data : '0;
      o_words   = words_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         issued_q <= '0;
         words_q  <= '0;
         to_q     <= '0;
         wr_q     <= 1'b0;
      end else begin
         issued_q <= issued_d;
         words_q  <= words_d;
         to_q     <= to_d;
         wr_q     <= o_rd_en;
      end
   end

endmodule

// File: rtl/ad_capture_ctrl.sv
// ad_capture_ctrl: ADC capture sequencer -- power-up, settle, start pulse, then a
// timeout-guarded drain of a programmable word count, optionally auto-rearming.
module ad_capture_ctrl
   import ad_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
   parameter int TO_W        = TO_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic              i_auto,
   input  logic [CNT_W-1:0]  i_recv_count,
   output logic              o_ad_open,
   output logic              o_st,
   input  logic              i_rd_empty,
   output logic              o_rd_en,
   input  logic [DATA_W-1:0] i_rd_data,
   input  logic              i_wr_full,
   output logic              o_wreq,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [CNT_W-1:0]  o_words
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] tgt_q, tgt_d;
   logic [TO_W-1:0]  settle_q, settle_d;
   logic             open_q, open_d;
   logic             err_q, err_d;
   logic             go, clr, run, last, timeout;

   always_comb begin
      go       = i_start && !i_abort && ((state_q == IDLE) || (state_q == ERR));
      run      = (state_q == CAPTURE) && !i_abort;
      state_d  = state_q;
      tgt_d    = tgt_q;
      settle_d = settle_q;
      open_d   = open_q;
      err_d    = err_q;
      clr      = 1'b0;
      case (state_q)
         IDLE, ERR: begin
            if (go) begin
               state_d  = PWRUP;
               tgt_d    = i_recv_count;
               settle_d = TO_W'(SETTLE_CYC);
               open_d   = 1'b1;
               err_d    = 1'b0;
               clr      = 1'b1;
            end
         end
         PWRUP: begin
            state_d  = (settle_q == TO_W'(1)) ? ARM : PWRUP;
            settle_d = settle_q - TO_W'(1);
         end
         ARM: state_d = (tgt_q == '0) ? DONE : CAPTURE;
         CAPTURE: begin
            if (last) begin
               state_d = DONE;
            end else if (timeout) begin
               state_d = ERR;
               err_d   = 1'b1;
               open_d  = 1'b0;
            end
         end
         DONE: begin
            // Auto re-arm keeps the ADC powered, so no second settle period.
            if (i_auto) begin
               state_d = ARM;
               tgt_d   = i_recv_count;
               clr     = 1'b1;
            end else begin
               state_d = IDLE;
               open_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (i_abort) begin
         state_d = IDLE;
         open_d  = 1'b0;
         clr     = 1'b0;
      end
      o_ad_open = open_q;
      o_err     = err_q;
      o_st      = (state_q == ARM) && !i_abort;
      o_done    = (state_q == DONE) && !i_abort;
      o_busy    = !((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         tgt_q    <= '0;
         settle_q <= '0;
         open_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         settle_q <= settle_d;
         open_q   <= open_d;
         err_q    <= err_d;
      end
   end

   ad_cap_xfer #(
      .DATA_W      (DATA_W),
      .CNT_W       (CNT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .TO_W        (TO_W)
   ) u_xfer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clr      (clr),
      .i_run      (run),
      .i_tgt      (tgt_q),
      .i_rd_empty (i_rd_empty),
      .i_wr_full  (i_wr_full),
      .i_rd_data  (i_rd_data),
      .o_rd_en    (o_rd_en),
      .o_wreq     (o_wreq),
      .o_wdata    (o_wdata),
      .o_words    (o_words),
      .o_last     (last),
      .o_timeout  (timeout)
   );

endmodule
